// File: rtl/intrpt_scheduler_pkg.sv
// Shared constants, FSM state type and slot-index helper for the interrupt scheduler.
package intrpt_scheduler_pkg;

  localparam logic [3:0]  RD_SLOT_NEXT = 4'hF;
  localparam logic [7:0]  NO_SLOT_ID   = 8'hFF;

  localparam int unsigned RD_DATA_W    = 48;
  localparam int unsigned RD_SLOT_LSB  = 40;
  localparam int unsigned RD_OVF_LSB   = 8;
  localparam int unsigned RD_PEND_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_e;

  function automatic logic [3:0] slot_inc(input logic [3:0] slot, input logic [3:0] last);
    return (slot == last) ? 4'h0 : slot + 4'h1;
  endfunction

endpackage

// File: rtl/intrpt_scheduler_if.sv
// Interrupt read bus between the SPI command decoder (master) and the scheduler (slave).
interface intrpt_scheduler_if;
  import intrpt_scheduler_pkg::*;

  logic                 rd_req;
  logic [3:0]           rd_slot;
  logic                 busy;
  logic                 rd_valid;
  logic [RD_DATA_W-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_slot,
    input  busy,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_slot,
    output busy,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/intrpt_slot_bank.sv
// One card slot: sticky pending/overflow flags, enable mask and its enabled-pending summary.
module intrpt_slot_bank #(
  parameter int unsigned NUM_INTRPTS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_INTRPTS-1:0] evt_i,
  input  logic                   clr_i,
  input  logic                   cfg_wr_i,
  input  logic [NUM_INTRPTS-1:0] cfg_en_i,
  output logic [NUM_INTRPTS-1:0] pending_o,
  output logic [NUM_INTRPTS-1:0] overflow_o,
  output logic                   any_en_o
);

  logic [NUM_INTRPTS-1:0] pending_q, pending_d;
  logic [NUM_INTRPTS-1:0] overflow_q, overflow_d;
  logic [NUM_INTRPTS-1:0] en_q, en_d;

  // A same-cycle event wins over the read clear: the bit stays pending and keeps its old overflow.
  always_comb begin
    pending_d  = evt_i | (pending_q & ~{NUM_INTRPTS{clr_i}});
    overflow_d = clr_i ? (overflow_q & evt_i) : (overflow_q | (evt_i & pending_q));
    en_d       = cfg_wr_i ? cfg_en_i : en_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q  <= '0;
      overflow_q <= '0;
      en_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      en_q       <= en_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign any_en_o   = |(pending_q & en_q);

endmodule

// File: rtl/intrpt_scheduler.sv
// Interrupt scheduler: per-slot sticky flags, MCU interrupt line and direct / round-robin read-to-clear.
module intrpt_scheduler
  import intrpt_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 7,
  parameter int unsigned NUM_INTRPTS = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_SLOTS*NUM_INTRPTS-1:0] evt_in,
  input  logic                             cfg_wr,
  input  logic [3:0]                       cfg_slot,
  input  logic [NUM_INTRPTS-1:0]           cfg_en,
  intrpt_scheduler_if.slave                rd_bus,
  output logic                             intrpt_out
);

  localparam logic [3:0] LAST_SLOT  = 4'(NUM_SLOTS - 1);
  localparam logic [3:0] SLOT_COUNT = 4'(NUM_SLOTS);

  logic [NUM_INTRPTS-1:0] pend [NUM_SLOTS];
  logic [NUM_INTRPTS-1:0] ovf  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   any_en;
  logic [NUM_SLOTS-1:0]   clr;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    intrpt_slot_bank #(
      .NUM_INTRPTS(NUM_INTRPTS)
    ) u_bank (
      .clk        (clk),
      .resetn     (resetn),
      .evt_i      (evt_in[s*NUM_INTRPTS +: NUM_INTRPTS]),
      .clr_i      (clr[s]),
      .cfg_wr_i   (cfg_wr && (cfg_slot == 4'(s))),
      .cfg_en_i   (cfg_en),
      .pending_o  (pend[s]),
      .overflow_o (ovf[s]),
      .any_en_o   (any_en[s])
    );
  end

  state_e               state_q, state_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           visits_q, visits_d;
  logic                 next_mode_q, next_mode_d;
  logic [3:0]           rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [RD_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                 intrpt_q, intrpt_d;

  logic [NUM_INTRPTS-1:0] sel_pend;
  logic [NUM_INTRPTS-1:0] sel_ovf;
  logic                   sel_any;
  logic [RD_DATA_W-1:0]   resp_data;
  logic                   go_resp;
  logic                   hit;

  // Candidate slot view; an out-of-range candidate reads as empty.
  always_comb begin
    sel_pend = '0;
    sel_ovf  = '0;
    sel_any  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (cand_q == 4'(i)) begin
        sel_pend = pend[i];
        sel_ovf  = ovf[i];
        sel_any  = any_en[i];
      end
    end
    resp_data = '0;
    resp_data[RD_SLOT_LSB +: 8]           = {4'h0, cand_q};
    resp_data[RD_OVF_LSB  +: NUM_INTRPTS] = sel_ovf;
    resp_data[RD_PEND_LSB +: NUM_INTRPTS] = sel_pend;
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    visits_d    = visits_q;
    next_mode_d = next_mode_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    go_resp     = 1'b0;
    hit         = 1'b0;
    clr         = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_bus.rd_req) begin
          state_d     = ST_SCAN;
          busy_d      = 1'b1;
          next_mode_d = (rd_bus.rd_slot == RD_SLOT_NEXT);
          cand_d      = (rd_bus.rd_slot == RD_SLOT_NEXT) ? rr_ptr_q : rd_bus.rd_slot;
          visits_d    = 4'h0;
        end
      end
      ST_SCAN: begin
        if (!next_mode_q) begin
          go_resp = 1'b1;
          hit     = (cand_q < SLOT_COUNT);
        end else if (sel_any) begin
          go_resp  = 1'b1;
          hit      = 1'b1;
          rr_ptr_d = slot_inc(cand_q, LAST_SLOT);
        end else if (visits_q == LAST_SLOT) begin
          go_resp = 1'b1;
        end else begin
          cand_d   = slot_inc(cand_q, LAST_SLOT);
          visits_d = visits_q + 4'h1;
        end
        if (go_resp) begin
          state_d    = ST_RESP;
          rd_valid_d = 1'b1;
          rd_data_d  = hit ? resp_data : {NO_SLOT_ID, {(RD_DATA_W-8){1'b0}}};
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear lands on the same edge that captures the response.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      clr[i] = go_resp && hit && (cand_q == 4'(i));
    end

    intrpt_d = |any_en;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      visits_q    <= '0;
      next_mode_q <= 1'b0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      intrpt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      visits_q    <= visits_d;
      next_mode_q <= next_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      intrpt_q    <= intrpt_d;
    end
  end

  assign rd_bus.busy     = busy_q;
  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;
  assign intrpt_out      = intrpt_q;

endmodule

// File: tb/tb_intrpt_scheduler.sv
// Directed plus randomized bench for intrpt_scheduler against a transaction-level flag model.
module tb_intrpt_scheduler;

  localparam int NS = 7;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [27:0] evt_in = '0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_slot = '0;
  logic [3:0]  cfg_en = '0;
  logic        intrpt_out;

  intrpt_scheduler_if rd_bus();

  intrpt_scheduler #(
    .NUM_SLOTS(NS),
    .NUM_INTRPTS(NI)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .evt_in     (evt_in),
    .cfg_wr     (cfg_wr),
    .cfg_slot   (cfg_slot),
    .cfg_en     (cfg_en),
    .rd_bus     (rd_bus),
    .intrpt_out (intrpt_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_pend [NS];
  logic [3:0] m_ovf  [NS];
  logic [3:0] m_en   [NS];
  int         m_rr;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = '0;
      m_ovf[s]  = '0;
      m_en[s]   = '0;
    end
    m_rr = 0;
  endtask

  function automatic logic model_any();
    for (int s = 0; s < NS; s++)
      if ((m_pend[s] & m_en[s]) != 4'h0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_evt(input logic [27:0] e, input int skip_slot);
    for (int s = 0; s < NS; s++) begin
      if (s == skip_slot) continue;
      for (int i = 0; i < NI; i++) begin
        if (e[s*NI+i]) begin
          if (m_pend[s][i]) m_ovf[s][i] = 1'b1;
          m_pend[s][i] = 1'b1;
        end
      end
    end
  endtask

  // Expected result and latency of a read issued now; applies read-to-clear and pointer advance.
  task automatic model_read(input logic [3:0] slot, input logic [27:0] ev_clr,
                            output logic [47:0] d, output int lat);
    int found = -1;
    if (slot == 4'hF) begin
      lat = NS + 1;
      for (int k = 1; k <= NS; k++) begin
        int t = (m_rr + k - 1) % NS;
        if ((m_pend[t] & m_en[t]) != 4'h0) begin
          found = t;
          lat   = k + 1;
          break;
        end
      end
      if (found >= 0) m_rr = (found + 1) % NS;
    end else begin
      lat = 2;
      if (int'(slot) < NS) found = int'(slot);
    end
    if (found < 0) begin
      d = {8'hFF, 40'h0};
    end else begin
      logic [3:0] e;
      d = {8'(found), 24'h0, 4'h0, m_ovf[found], 4'h0, m_pend[found]};
      e = ev_clr[found*NI +: NI];
      m_ovf[found]  = m_ovf[found] & e;
      m_pend[found] = e;
    end
    model_evt(ev_clr, found);
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [27:0] e, input logic w, input logic [3:0] slot, input logic [3:0] en);
    evt_in   = e;
    cfg_wr   = w;
    cfg_slot = slot;
    cfg_en   = en;
    @(negedge clk);
    evt_in = '0;
    cfg_wr = 1'b0;
    model_evt(e, -1);
    if (w && int'(slot) < NS) m_en[int'(slot)] = en;
  endtask

  task automatic check_irq(input string tag);
    chk(tag, {47'h0, intrpt_out}, {47'h0, model_any()});
  endtask

  task automatic do_read(input string tag, input logic [3:0] slot, input logic [27:0] ev_clr, input bit poke);
    logic [47:0] exp_d;
    int          exp_lat;
    int          lat = 0;
    model_read(slot, ev_clr, exp_d, exp_lat);
    rd_bus.rd_req  = 1'b1;
    rd_bus.rd_slot = slot;
    @(negedge clk);
    rd_bus.rd_req = 1'b0;
    evt_in        = ev_clr;
    chk({tag, ".busy_start"}, {47'h0, rd_bus.busy}, 48'h1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        evt_in = '0;
        if (poke) begin
          rd_bus.rd_req  = 1'b1;
          rd_bus.rd_slot = 4'h1;
        end
      end
      if (c == 3) rd_bus.rd_req = 1'b0;
      if (rd_bus.rd_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    evt_in        = '0;
    rd_bus.rd_req = 1'b0;
    chk({tag, ".latency"}, 48'(lat), 48'(exp_lat));
    chk({tag, ".data"}, rd_bus.rd_data, exp_d);
    chk({tag, ".busy_valid"}, {47'h0, rd_bus.busy}, 48'h1);
    @(negedge clk);
    chk({tag, ".valid_drop"}, {47'h0, rd_bus.rd_valid}, 48'h0);
    chk({tag, ".busy_drop"}, {47'h0, rd_bus.busy}, 48'h0);
    chk({tag, ".data_held"}, rd_bus.rd_data, exp_d);
    check_irq({tag, ".irq_after"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          target;
    logic        saw;
    logic [3:0]  rs;
    int          pick;

    rd_bus.rd_req  = 1'b0;
    rd_bus.rd_slot = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.busy", {47'h0, rd_bus.busy}, 48'h0);
    chk("reset.valid", {47'h0, rd_bus.rd_valid}, 48'h0);
    chk("reset.data", rd_bus.rd_data, 48'h0);
    chk("reset.irq", {47'h0, intrpt_out}, 48'h0);
    resetn = 1'b1;
    quiet(2);

    // Idle after reset, direct read of an empty slot
    check_irq("t1.irq");
    do_read("t1.rd1", 4'h1, '0, 1'b0);

    // Enabled slot 1 with a repeated event: pending plus overflow
    pulse('0, 1'b1, 4'h1, 4'hF);
    pulse(28'h40, 1'b0, 4'h0, 4'h0);
    pulse(28'h40, 1'b0, 4'h0, 4'h0);
    quiet(1);
    check_irq("t2.irq");
    do_read("t2.rd1", 4'h1, '0, 1'b0);

    // Round-robin: slots 2 and 5, then nothing
    pulse('0, 1'b1, 4'h2, 4'hF);
    pulse('0, 1'b1, 4'h5, 4'hF);
    pulse(28'h0000200, 1'b0, 4'h0, 4'h0);
    pulse(28'h0800000, 1'b0, 4'h0, 4'h0);
    quiet(1);
    check_irq("t3.irq");
    do_read("t3.next_a", 4'hF, '0, 1'b0);
    do_read("t3.next_b", 4'hF, '0, 1'b0);
    do_read("t3.next_c", 4'hF, '0, 1'b0);

    // Event on the bit being cleared in the clear cycle
    pulse('0, 1'b1, 4'h0, 4'h1);
    pulse(28'h1, 1'b0, 4'h0, 4'h0);
    quiet(1);
    do_read("t4.clr_evt", 4'h0, 28'h1, 1'b0);
    do_read("t4.reread", 4'h0, '0, 1'b0);

    // Masked pending on slot 3
    pulse(28'h0001000, 1'b0, 4'h0, 4'h0);
    quiet(1);
    check_irq("t5.irq_masked");
    do_read("t5.next_skip", 4'hF, '0, 1'b0);
    do_read("t5.direct3", 4'h3, '0, 1'b0);

    // rd_req during busy, out-of-range slot
    do_read("t6.poke", 4'hF, '0, 1'b1);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw = saw | rd_bus.rd_valid;
    end
    chk("t6.no_extra_valid", {47'h0, saw}, 48'h0);
    do_read("t6.slot9", 4'h9, '0, 1'b0);

    // Reset in the middle of a long scan
    target = (m_rr + NS - 1) % NS;
    pulse('0, 1'b1, 4'(target), 4'hF);
    pulse(28'(1) << (target * NI), 1'b0, 4'h0, 4'h0);
    quiet(1);
    check_irq("t7.irq_before");
    rd_bus.rd_req  = 1'b1;
    rd_bus.rd_slot = 4'hF;
    @(negedge clk);
    rd_bus.rd_req = 1'b0;
    quiet(2);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("t7.rst_busy", {47'h0, rd_bus.busy}, 48'h0);
    chk("t7.rst_valid", {47'h0, rd_bus.rd_valid}, 48'h0);
    chk("t7.rst_data", rd_bus.rd_data, 48'h0);
    chk("t7.rst_irq", {47'h0, intrpt_out}, 48'h0);
    @(negedge clk);
    resetn = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | rd_bus.rd_valid;
    end
    chk("t7.no_valid", {47'h0, saw}, 48'h0);
    check_irq("t7.irq_after");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        pulse(28'($urandom & $urandom & $urandom), ($urandom_range(0, 2) == 0),
              4'($urandom_range(0, 8)), 4'($urandom));
      end
      quiet(1);
      check_irq("rnd.irq");
      pick = int'($urandom_range(0, 9));
      if (pick < NS) rs = 4'(pick);
      else if (pick == NS) rs = 4'h9;
      else rs = 4'hF;
      do_read("rnd.read", rs, '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
